// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian words, writes them from word 0,
// verifies an XOR checksum, and holds the pipeline in reset until a good image is in place.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(2**ADDR_W);

  state_t            state;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_idx;
  logic [15:0]       length;
  logic [7:0]        checksum;
  logic [23:0]       shift;
  logic              accept;
  logic [ADDR_W:0]   word_inc;
  logic [15:0]       len_full;

  // Gated by Rst so the source sees no readiness while the loader is held in reset.
  assign byte_ready = Rst && (state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
  assign accept     = byte_valid && byte_ready;
  assign word_inc   = word_cnt + 1'b1;
  assign len_full   = {length[15:8], byte_data};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= S_LEN_HI;
      word_cnt   <= '0;
      byte_idx   <= '0;
      length     <= '0;
      checksum   <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      load_done  <= (state == S_DONE) && !reload;
      cpu_rst_n  <= (state == S_DONE) && !reload;
      load_error <= (state == S_ERR) && !reload;

      case (state)
        S_LEN_HI: begin
          if (accept) begin
            length[15:8] <= byte_data;
            state        <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            length[7:0] <= byte_data;
            if ({1'b0, len_full} > MAX_LEN)
              state <= S_ERR;
            else if (len_full == 16'd0)
              state <= S_CSUM;
            else
              state <= S_DATA;
          end
        end

        S_DATA: begin
          if (accept) begin
            shift    <= {shift[15:0], byte_data};
            checksum <= checksum ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte completes the word: launch the write pulse on the same edge.
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {shift, byte_data};
              state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          word_cnt <= word_inc;
          state    <= (16'(word_inc) == length) ? S_CSUM : S_DATA;
        end

        S_CSUM: begin
          if (accept)
            state <= (byte_data == checksum) ? S_DONE : S_ERR;
        end

        S_DONE, S_ERR: begin
          if (reload) begin
            state    <= S_LEN_HI;
            word_cnt <= '0;
            byte_idx <= '0;
            length   <= '0;
            checksum <= '0;
            shift    <= '0;
          end
        end

        default: state <= S_LEN_HI;
      endcase
    end
  end

endmodule
